// File: rtl/ucode_sequencer.sv
// Microcode next-address sequencer: maps a bytecode opcode to its first
// microinstruction and walks the ROM chain, issuing one micro-op per handshake.
module ucode_sequencer #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned OP_W       = 8,
  parameter int unsigned UCODE_BASE = 256,
  parameter int unsigned MAX_UOPS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bc_valid,
  input  logic [OP_W-1:0]   bc_opcode,
  output logic              bc_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] rom_next,
  output logic              uop_valid,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  input  logic              uop_ready,
  output logic              unsup_valid,
  output logic [OP_W-1:0]   unsup_op,
  output logic              done_valid,
  output logic [4:0]        done_count,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_OVERRUN = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   unsup_op_d;
  logic              unsup_valid_d;
  logic              done_valid_d;
  logic [4:0]        done_count_d;
  logic [1:0]        fault_code_d;
  logic              next_zero;
  logic              next_legal;

  // The all-ones address is the ROM's unprogrammed default, so it is never legal.
  assign next_zero  = (rom_next == '0);
  assign next_legal = (rom_next >= ADDR_W'(UCODE_BASE)) && (rom_next != '1);

  assign bc_ready  = (state_q == S_IDLE);
  assign uop_valid = (state_q == S_RUN);
  assign uop_addr  = cur_q;
  assign uop_last  = (state_q == S_RUN) && next_zero;
  assign fault     = (state_q == S_FAULT);

  always_comb begin
    case (state_q)
      S_IDLE:  rom_addr = ADDR_W'(bc_opcode);
      S_RUN:   rom_addr = cur_q;
      default: rom_addr = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    unsup_op_d    = unsup_op;
    unsup_valid_d = 1'b0;
    done_valid_d  = 1'b0;
    done_count_d  = done_count;
    fault_code_d  = fault_code;
    case (state_q)
      S_IDLE: begin
        if (bc_valid) begin
          if (next_zero) begin
            unsup_op_d    = bc_opcode;
            unsup_valid_d = 1'b1;
          end else if (next_legal) begin
            cur_d   = rom_next;
            cnt_d   = 5'd1;
            state_d = S_RUN;
          end else begin
            fault_code_d = FC_ILLEGAL;
            state_d      = S_FAULT;
          end
        end
      end
      S_RUN: begin
        if (uop_ready) begin
          if (next_zero) begin
            done_valid_d = 1'b1;
            done_count_d = cnt_q;
            state_d      = S_IDLE;
          end else if (next_legal) begin
            if (cnt_q == 5'(MAX_UOPS)) begin
              fault_code_d = FC_OVERRUN;
              state_d      = S_FAULT;
            end else begin
              cur_d = rom_next;
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            fault_code_d = FC_ILLEGAL;
            state_d      = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          cur_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      unsup_op    <= '0;
      unsup_valid <= 1'b0;
      done_valid  <= 1'b0;
      done_count  <= '0;
      fault_code  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      unsup_op    <= unsup_op_d;
      unsup_valid <= unsup_valid_d;
      done_valid  <= done_valid_d;
      done_count  <= done_count_d;
      fault_code  <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a behavioural ROM and a scoreboard
// queue of expected micro-op addresses.
module tb_ucode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bc_valid;
  logic [7:0] bc_opcode;
  logic       bc_ready;
  logic [8:0] rom_addr;
  logic [8:0] rom_next;
  logic       uop_valid;
  logic [8:0] uop_addr;
  logic       uop_last;
  logic       uop_ready;
  logic       unsup_valid;
  logic [7:0] unsup_op;
  logic       done_valid;
  logic [4:0] done_count;
  logic       fault;
  logic [1:0] fault_code;
  logic       fault_clr;

  int rom_mode;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] addr;
    logic       last;
  } exp_t;
  exp_t q[$];

  ucode_sequencer #(
    .ADDR_W(9), .OP_W(8), .UCODE_BASE(256), .MAX_UOPS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bc_valid(bc_valid), .bc_opcode(bc_opcode), .bc_ready(bc_ready),
    .rom_addr(rom_addr), .rom_next(rom_next),
    .uop_valid(uop_valid), .uop_addr(uop_addr), .uop_last(uop_last),
    .uop_ready(uop_ready),
    .unsup_valid(unsup_valid), .unsup_op(unsup_op),
    .done_valid(done_valid), .done_count(done_count),
    .fault(fault), .fault_code(fault_code), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  // mode 0: normal image; mode 1: 256 loops on itself; mode 2: 256 -> 511
  function automatic logic [8:0] rom_f(input logic [8:0] a, input int mode);
    if (a == 9'd256 && mode == 1) return 9'd256;
    if (a == 9'd256 && mode == 2) return 9'd511;
    case (a)
      9'h059: return 9'd256;
      9'h00B: return 9'd268;
      9'h08C: return 9'd302;
      9'h000: return 9'd0;
      9'h0CA: return 9'd0;
      9'd256: return 9'd257;
      9'd257: return 9'd0;
      9'd268: return 9'd0;
      9'd302: return 9'd303;
      9'd303: return 9'd304;
      9'd304: return 9'd259;
      9'd259: return 9'd0;
      default: return 9'd511;
    endcase
  endfunction

  always_comb rom_next = rom_f(rom_addr, rom_mode);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] a, input logic l);
    exp_t e;
    e.addr = a;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic run_chain(input logic [7:0] op, input bit toggle, input bit exp_done,
                           input logic [4:0] exp_cnt, input logic [1:0] exp_fc);
    int cyc;
    bit rdy;
    check("bc_ready_before", bc_ready, 1'b1);
    bc_valid  = 1'b1;
    bc_opcode = op;
    step();
    bc_valid = 1'b0;
    rdy = toggle ? 1'b0 : 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      uop_ready = rdy;
      check("uop_valid", uop_valid, 1'b1);
      if (uop_valid) begin
        check("uop_addr", uop_addr, q[0].addr);
        check("uop_last", uop_last, q[0].last);
        if (rdy) void'(q.pop_front());
      end
      step();
      cyc++;
      if (toggle) rdy = !rdy;
    end
    uop_ready = 1'b0;
    if (q.size() > 0) begin
      check("chain_timeout", q.size(), 0);
      q.delete();
    end
    check("uop_valid_after", uop_valid, 1'b0);
    if (exp_done) begin
      check("done_valid", done_valid, 1'b1);
      check("done_count", done_count, exp_cnt);
      check("bc_ready_after", bc_ready, 1'b1);
      step();
      check("done_pulse_end", done_valid, 1'b0);
    end else begin
      check("fault", fault, 1'b1);
      check("fault_code", fault_code, exp_fc);
      check("bc_ready_fault", bc_ready, 1'b0);
      check("done_in_fault", done_valid, 1'b0);
    end
  endtask

  task automatic unsup(input logic [7:0] op);
    check("bc_ready_unsup", bc_ready, 1'b1);
    bc_valid  = 1'b1;
    bc_opcode = op;
    step();
    bc_valid = 1'b0;
    check("unsup_valid", unsup_valid, 1'b1);
    check("unsup_op", unsup_op, op);
    check("unsup_no_uop", uop_valid, 1'b0);
    check("unsup_bc_ready", bc_ready, 1'b1);
    step();
    check("unsup_pulse_end", unsup_valid, 1'b0);
    check("unsup_op_held", unsup_op, op);
  endtask

  task automatic clear_fault(input logic [1:0] held_fc);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clr_fault", fault, 1'b0);
    check("clr_bc_ready", bc_ready, 1'b1);
    check("clr_code_held", fault_code, held_fc);
  endtask

  initial begin
    rst_n     = 1'b0;
    bc_valid  = 1'b0;
    bc_opcode = '0;
    uop_ready = 1'b0;
    fault_clr = 1'b0;
    rom_mode  = 0;
    step();
    step();
    check("rst_bc_ready", bc_ready, 1'b1);
    check("rst_uop_valid", uop_valid, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_fault_code", fault_code, 2'b00);
    check("rst_done_count", done_count, 5'd0);
    check("rst_unsup_op", unsup_op, 8'h00);
    check("rst_pulses", {unsup_valid, done_valid}, 2'b00);
    rst_n = 1'b1;
    step();

    push(9'd256, 1'b0); push(9'd257, 1'b1);
    run_chain(8'h59, 1'b0, 1'b1, 5'd2, 2'b00);

    push(9'd268, 1'b1);
    run_chain(8'h0B, 1'b0, 1'b1, 5'd1, 2'b00);

    unsup(8'hCA);
    unsup(8'h00);

    push(9'd302, 1'b0); push(9'd303, 1'b0); push(9'd304, 1'b0); push(9'd259, 1'b1);
    run_chain(8'h8C, 1'b1, 1'b1, 5'd4, 2'b00);

    // unprogrammed entry point
    run_chain(8'h10, 1'b0, 1'b0, 5'd0, 2'b01);
    clear_fault(2'b01);

    rom_mode = 1;
    for (int i = 0; i < 16; i++) push(9'd256, 1'b0);
    run_chain(8'h59, 1'b0, 1'b0, 5'd0, 2'b10);
    clear_fault(2'b10);

    rom_mode = 2;
    push(9'd256, 1'b0);
    run_chain(8'h59, 1'b0, 1'b0, 5'd0, 2'b01);
    clear_fault(2'b01);

    rom_mode = 0;
    bc_valid  = 1'b1;
    bc_opcode = 8'h8C;
    step();
    bc_valid = 1'b0;
    check("mid_uop_valid", uop_valid, 1'b1);
    check("mid_uop_addr", uop_addr, 9'd302);
    step();
    rst_n = 1'b0;
    #1;
    check("arst_uop_valid", uop_valid, 1'b0);
    check("arst_bc_ready", bc_ready, 1'b1);
    check("arst_fault_code", fault_code, 2'b00);
    check("arst_done_count", done_count, 5'd0);
    check("arst_unsup_op", unsup_op, 8'h00);
    check("arst_uop_addr", uop_addr, 9'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_no_done", done_valid, 1'b0);
    check("post_rst_idle", bc_ready, 1'b1);

    push(9'd268, 1'b1);
    run_chain(8'h0B, 1'b0, 1'b1, 5'd1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
